mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles waited for dmem_gnt_i or dmem_rvalid_i before abort.
- REQ-002 clk_i  in  1  single clock, all state on rising edge.
- REQ-003 rst_i  in  1  reset, synchronous, active-low.
- REQ-004 valid_i  in  1  execute-stage result valid this cycle.
- REQ-005 ready_o  out  1  stage can accept; transfer occurs when valid_i && ready_o.
- REQ-006 pc_i  in  32  PC of the instruction.
- REQ-007 alu_i  in  32  ALU result: memory byte address or writeback value.
- REQ-008 DataB_i  in  32  rs2 data, used as store data.
- REQ-009 funct3_i  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- REQ-010 MemRd_i / MemWr_i  in  1 each  load / store request; both high is illegal and treated as store.
- REQ-011 WBSel_i  in  2  writeback select: 00 memory, 01 alu_i, 10 pc_i+4, 11 zero.
- REQ-012 RegWEn_i  in  1; AddrD_i  in  5  destination write enable and index.
- REQ-013 dmem_req_o, dmem_we_o  out  1; dmem_addr_o  out  32 (word-aligned); dmem_wdata_o  out  32; dmem_be_o  out  4.
- REQ-014 dmem_gnt_i, dmem_rvalid_i  in  1; dmem_rdata_i  in  32.
- REQ-015 valid_o  out  1  one-cycle pulse, DataD_o/RegWEn_o/AddrD_o valid.
- REQ-016 DataD_o  out  32; RegWEn_o  out  1; AddrD_o  out  5  writeback bundle.
- REQ-017 misalign_o, bus_err_o  out  1  one-cycle error pulses, coincident with valid_o.

Function
- REQ-018 FSM states IDLE, REQ, RESP, DONE; ready_o=1 only in IDLE.
- REQ-019 Accepted transfer latches all inputs; non-memory op: IDLE->DONE, valid_o asserted exactly 1 cycle after acceptance.
- REQ-020 Alignment: W requires addr[1:0]=00, H/HU require addr[0]=0, B/BU always aligned; undefined funct3 is misaligned.
- REQ-021 Misaligned memory op: no bus request, IDLE->DONE, misalign_o=1 and RegWEn_o=0 with valid_o.
- REQ-022 Aligned memory op: IDLE->REQ; dmem_req_o held high with stable addr/we/wdata/be until dmem_gnt_i sampled high.
- REQ-023 dmem_addr_o = {addr[31:2],2'b00}; dmem_be_o: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111; loads use same BE.
- REQ-024 Store data replicated: B {4{byte}}, H {2{half}}, W as-is.
- REQ-025 Store: gnt ends transaction, REQ->DONE, RegWEn_o forced 0.
- REQ-026 Load: gnt -> RESP; dmem_req_o drops; wait dmem_rvalid_i; rvalid -> DONE with rdata captured.
- REQ-027 dmem_rvalid_i outside RESP is ignored.
- REQ-028 Load extraction: byte/half selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
- REQ-029 DataD_o per WBSel_i; pc_i+4 wraps modulo 2^32.
- REQ-030 Timeout counter resets on entering REQ and RESP; reaching TIMEOUT_CYCLES without the awaited signal -> DONE, bus_err_o=1, RegWEn_o=0, dmem_req_o low.
- REQ-031 DONE lasts one cycle then IDLE; earliest next acceptance is the cycle after DONE.
- REQ-032 Outside valid_o, DataD_o holds last value; RegWEn_o, misalign_o, bus_err_o are 0.

Reset
- REQ-033 rst_i low at a clock edge: FSM IDLE, counter 0, all outputs 0 (ready_o 0 during reset, 1 first cycle after release).
- REQ-034 Reset mid-transaction abandons it: dmem_req_o 0 next cycle, no valid_o, late gnt/rvalid ignored.

Verification
- REQ-035 WBSel=01, alu_i=0x1234 accepted -> next cycle valid_o=1, DataD_o=0x1234, RegWEn_o=RegWEn_i.
- REQ-036 LB addr 0x1003, rdata 0x80FF_FF7F, gnt 2 cycles late, rvalid 1 cycle later -> be=1000, addr 0x1000, DataD_o=0xFFFF_FF80.
- REQ-037 SH addr 0x2002, DataB=0xABCD_1234 -> be=1100, wdata=0x1234_1234, we=1, valid_o with RegWEn_o=0.
- REQ-038 LW addr 0x3001 -> no dmem_req_o, misalign_o=1, RegWEn_o=0, 1-cycle latency.
- REQ-039 LW, gnt never asserted -> bus_err_o after TIMEOUT_CYCLES (16) in REQ, back to IDLE.
- REQ-040 rst_i low while in RESP -> dmem_req_o/valid_o 0, FSM IDLE, subsequent rvalid produces no output.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage with a req/gnt/rvalid data bus
// and a one-pulse writeback bundle per accepted instruction.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] DataB_i,
  input  logic [2:0]  funct3_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic [1:0]  WBSel_i,
  input  logic        RegWEn_i,
  input  logic [4:0]  AddrD_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [31:0] DataD_o,
  output logic        RegWEn_o,
  output logic [4:0]  AddrD_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] data_b;
    logic [2:0]  funct3;
    logic        wr;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic [4:0]  addr_d;
  } op_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_t           op_q, op_in;

  logic        accept, align_ok, in_req, idle;
  logic        fin, fin_mis, fin_bus, fin_ld;
  logic [31:0] cur_pc, cur_alu;
  logic [1:0]  cur_wb;
  logic        cur_we, cur_wr;
  logic [4:0]  cur_ad;
  logic [31:0] rd_shift, ld_val, wb_val;

  assign idle    = state_q == IDLE;
  assign ready_o = rst_i && idle;
  assign accept  = valid_i && ready_o;

  assign op_in = '{pc: pc_i, alu: alu_i, data_b: DataB_i,
                   funct3: funct3_i, wr: MemWr_i,
                   wb_sel: WBSel_i, reg_we: RegWEn_i,
                   addr_d: AddrD_i};

  // single-cycle completions finish before op_q is loaded
  assign cur_pc  = idle ? pc_i     : op_q.pc;
  assign cur_alu = idle ? alu_i    : op_q.alu;
  assign cur_wb  = idle ? WBSel_i  : op_q.wb_sel;
  assign cur_we  = idle ? RegWEn_i : op_q.reg_we;
  assign cur_wr  = idle ? MemWr_i  : op_q.wr;
  assign cur_ad  = idle ? AddrD_i  : op_q.addr_d;

  always_comb begin
    align_ok = 1'b0;
    unique case (funct3_i)
      3'b000, 3'b100: align_ok = 1'b1;
      3'b001, 3'b101: align_ok = !alu_i[0];
      3'b010:         align_ok = alu_i[1:0] == 2'b00;
      default:        align_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    fin_mis = 1'b0;
    fin_bus = 1'b0;
    fin_ld  = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        if (!(MemRd_i || MemWr_i)) begin
          state_d = DONE;
          fin     = 1'b1;
        end else if (!align_ok) begin
          state_d = DONE;
          fin     = 1'b1;
          fin_mis = 1'b1;
        end else begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: if (dmem_gnt_i) begin
        cnt_d = '0;
        if (op_q.wr) begin
          state_d = DONE;
          fin     = 1'b1;
        end else begin
          state_d = RESP;
        end
      end else if (cnt_q == CNT_LAST) begin
        state_d = DONE;
        fin     = 1'b1;
        fin_bus = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: if (dmem_rvalid_i) begin
        state_d = DONE;
        fin     = 1'b1;
        fin_ld  = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        state_d = DONE;
        fin     = 1'b1;
        fin_bus = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_shift = dmem_rdata_i >> {op_q.alu[1:0], 3'b000};

  always_comb begin
    ld_val = rd_shift;
    unique case (1'b1)
      op_q.funct3 == 3'b000: ld_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      op_q.funct3 == 3'b100: ld_val = {24'h0, rd_shift[7:0]};
      op_q.funct3 == 3'b001: ld_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      op_q.funct3 == 3'b101: ld_val = {16'h0, rd_shift[15:0]};
      default:               ld_val = rd_shift;
    endcase
  end

  always_comb begin
    wb_val = '0;
    unique case (cur_wb)
      2'b00:   wb_val = fin_ld ? ld_val : '0;
      2'b01:   wb_val = cur_alu;
      2'b10:   wb_val = cur_pc + 32'd4;
      default: wb_val = '0;
    endcase
  end

  assign in_req      = state_q == REQ;
  assign dmem_req_o  = in_req;
  assign dmem_we_o   = in_req && op_q.wr;
  assign dmem_addr_o = in_req ? {op_q.alu[31:2], 2'b00} : '0;

  always_comb begin
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    if (in_req) begin
      unique case (op_q.funct3[1:0])
        2'b00: begin
          dmem_be_o    = 4'b0001 << op_q.alu[1:0];
          dmem_wdata_o = {4{op_q.data_b[7:0]}};
        end
        2'b01: begin
          dmem_be_o    = 4'b0011 << op_q.alu[1:0];
          dmem_wdata_o = {2{op_q.data_b[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = op_q.data_b;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      valid_o    <= 1'b0;
      DataD_o    <= '0;
      RegWEn_o   <= 1'b0;
      AddrD_o    <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_o    <= fin;
      misalign_o <= fin_mis;
      bus_err_o  <= fin_bus;
      RegWEn_o   <= fin && cur_we && !cur_wr && !fin_mis && !fin_bus;
      if (accept) op_q <= op_in;
      if (fin) begin
        DataD_o <= wb_val;
        AddrD_o <= cur_ad;
      end
    end
  end

endmodule
